// File: rtl/eth_cmd_regs_axil.sv
// eth_cmd_regs_axil: AXI4-Lite register file for the Ethernet command path.
// Generic RW registers with byte strobes, a write-only CMD port that feeds a
// command FIFO drained over valid/ready, and a STATUS word with FIFO level,
// full/empty and a sticky W1C overflow flag.
//
// Write FSM                         Read FSM
//   state  | meaning                 state  | meaning
//   W_IDLE | waiting for AW+W        R_IDLE | waiting for AR
//   W_RESP | BVALID held until BREADY  R_DATA | RVALID held until RREADY
module eth_cmd_regs_axil #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int CMD_DEPTH  = 8,
  parameter logic [DATA_WIDTH-1:0] REG_RESET = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [DATA_WIDTH-1:0]          cmd_data,
  output logic                           cmd_valid,
  input  logic                           cmd_ready
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int PTR_W    = $clog2(CMD_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [IDX_W-1:0] IDX_CMD    = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NUM_REGS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CMD_DEPTH);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t r_wstate, w_wstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_mem  [CMD_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;

  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic [IDX_W-1:0]      w_awidx;
  logic [IDX_W-1:0]      w_aridx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push_req;
  logic                  w_push_ok;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic [1:0]            w_rresp_nxt;
  logic [1:0]            w_bresp_nxt;
  logic                  w_unused;

  // PROT and the sub-word address bits carry no meaning here.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign w_awidx = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_aridx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  // Write FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state and channel handshakes; AW and W are taken together.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    w_wr_hs       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID && !ARESET) begin
          S_AXI_AWREADY = 1'b1;
          S_AXI_WREADY  = 1'b1;
          w_wr_hs       = 1'b1;
          w_wstate_nxt  = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write response code for the word being accepted this cycle.
  always_comb begin
    w_bresp_nxt = RESP_SLVERR;
    if (w_awidx < IDX_CMD)         w_bresp_nxt = RESP_OKAY;
    else if (w_awidx == IDX_CMD)   w_bresp_nxt = w_push_ok ? RESP_OKAY : RESP_SLVERR;
    else if (w_awidx == IDX_STATUS) w_bresp_nxt = RESP_OKAY;
  end

  // Latch BRESP on the AW/W handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)       r_bresp <= RESP_OKAY;
    else if (w_wr_hs) r_bresp <= w_bresp_nxt;
  end

  assign S_AXI_BRESP = r_bresp;

  // Generic RW registers, byte-lane masked by WSTRB.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= REG_RESET;
    end else if (w_wr_hs) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_awidx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (S_AXI_WSTRB[b]) r_regs[i][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && cmd_ready;
  assign w_push_req = w_wr_hs && (w_awidx == IDX_CMD);
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && !w_push_ok;
  assign w_ovf_clr  = w_wr_hs && (w_awidx == IDX_STATUS) &&
                      S_AXI_WSTRB[3] && S_AXI_WDATA[31];

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge ACLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= S_AXI_WDATA;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign cmd_data  = r_mem[r_rd_ptr];
  assign cmd_valid = !w_empty;

  // Sticky overflow; a dropped push beats a simultaneous clear.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)         r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (w_ovf_clr) r_overflow <= 1'b0;
  end

  // STATUS word assembly.
  always_comb begin
    w_status      = '0;
    w_status[8:0] = 9'(r_count);
    w_status[16]  = w_full;
    w_status[17]  = w_empty;
    w_status[31]  = r_overflow;
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state and channel handshakes.
  always_comb begin
    w_rstate_nxt  = r_rstate;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    w_rd_hs       = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (S_AXI_ARVALID && !ARESET) begin
          S_AXI_ARREADY = 1'b1;
          w_rd_hs       = 1'b1;
          w_rstate_nxt  = R_DATA;
        end
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read data mux; CMD reads as zero, unmapped words return SLVERR.
  always_comb begin
    w_rdata_nxt = '0;
    w_rresp_nxt = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_aridx == IDX_W'(i)) begin
        w_rdata_nxt = r_regs[i];
        w_rresp_nxt = RESP_OKAY;
      end
    end
    if (w_aridx == IDX_CMD) begin
      w_rresp_nxt = RESP_OKAY;
    end else if (w_aridx == IDX_STATUS) begin
      w_rdata_nxt = w_status;
      w_rresp_nxt = RESP_OKAY;
    end
  end

  // Capture read data on the AR handshake; held stable while RVALID.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_rd_hs) begin
      r_rdata <= w_rdata_nxt;
      r_rresp <= w_rresp_nxt;
    end
  end

  assign S_AXI_RDATA = r_rdata;
  assign S_AXI_RRESP = r_rresp;

endmodule
